// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding scoreboard.
package fwd_pkg;

    // Slot rd is stored at this fixed width; narrower AW values are zero-extended.
    localparam int FWD_AW_MAX = 8;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  vld;
        logic [FWD_AW_MAX-1:0] rd;
        logic                  load;
    } fwd_slot_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand youngest-first producer search: returns forward select and load-use hazard.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int SW       = fwd_sel_w(DEPTH)
) (
    input  fwd_slot_t [DEPTH-1:0] slots,
    input  logic [AW-1:0]         rs,
    input  logic                  used,
    output logic [SW-1:0]         sel,
    output logic                  hazard
);

    always_comb begin
        sel    = SW'(FWD_SEL_RF);
        hazard = 1'b0;
        if (used && rs != '0) begin
            // Walk oldest to youngest so the youngest match is the last one written.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slots[k].vld && slots[k].rd == FWD_AW_MAX'(rs)) begin
                    if (slots[k].load && k < LOAD_LAT) begin
                        sel    = SW'(FWD_SEL_RF);
                        hazard = 1'b1;
                    end else begin
                        sel    = SW'(k + 1);
                        hazard = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard unit with a DEPTH-slot destination scoreboard past EX.
// Define FWD_PERF_CNT_EN to add the saturating hazard_cnt stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int NSRC     = 2,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int SW       = fwd_sel_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 ex_regw,
    input  logic                 ex_load,
    input  logic [AW-1:0]        ex_rd,
    input  logic [NSRC*AW-1:0]   ex_rs,
    input  logic [NSRC-1:0]      ex_rs_used,
    input  logic                 mem_stall,
    input  logic                 flush,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic                 hazard,
    output logic [DEPTH-1:0]     slot_vld
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]          hazard_cnt
`endif
);

    fwd_slot_t [DEPTH-1:0] slot_q, slot_d;
    logic      [NSRC-1:0]  op_haz;

    for (genvar i = 0; i < NSRC; i++) begin : g_match
        fwd_match #(
            .DEPTH    (DEPTH),
            .AW       (AW),
            .LOAD_LAT (LOAD_LAT),
            .SW       (SW)
        ) u_match (
            .slots  (slot_q),
            .rs     (ex_rs[i*AW +: AW]),
            .used   (ex_rs_used[i]),
            .sel    (fwd_sel[i*SW +: SW]),
            .hazard (op_haz[i])
        );
    end

    assign hazard = ex_valid & ~flush & (|op_haz);

    for (genvar k = 0; k < DEPTH; k++) begin : g_vld
        assign slot_vld[k] = slot_q[k].vld;
    end

    always_comb begin
        slot_d = slot_q;
        if (!mem_stall) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            // A stalled or flushed EX instruction must not enter; a bubble does instead.
            if (!hazard && !flush) begin
                slot_d[0].vld  = ex_valid & ex_regw;
                slot_d[0].rd   = FWD_AW_MAX'(ex_rd);
                slot_d[0].load = ex_load;
            end else begin
                slot_d[0] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && !mem_stall && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hazard_cnt = cnt_q;
`endif

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the pipelined RISC-V core. It holds its own shift-register scoreboard of in-flight destination registers past EX, with DEPTH tracked stages. Each cycle it returns a per-operand forwarding select for the instruction in EX, and raises a stall request when a load result is not yet available. It sits beside the ID/EX→EX boundary and drives the EX operand muxes and the pipeline hazard control.

## Interface
Parameters:
- DEPTH, 2, number of tracked stages past EX (slot 0 = EX/MEM, slot DEPTH-1 = last before write-back)
- NSRC, 2, number of source operands checked per instruction
- AW, 5, register address width
- LOAD_LAT, 1, first slot index at which load data is forwardable (1 ≤ LOAD_LAT ≤ DEPTH-1)
- SW, $clog2(DEPTH+1), forward-select width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX holds a real instruction
- ex_regw  in  1  EX instruction writes rd
- ex_load  in  1  EX instruction is a load
- ex_rd  in  AW  EX destination register
- ex_rs  in  NSRC*AW  EX source registers, operand i at [i*AW +: AW]
- ex_rs_used  in  NSRC  operand i actually read
- mem_stall  in  1  back-end stall, all slots hold
- flush  in  1  kill EX instruction this cycle
- fwd_sel  out  NSRC*SW  per operand: 0 = register file, k = data from slot k-1
- hazard  out  1  load-use stall request
- slot_vld  out  DEPTH  slot valid+regw flags (debug / write-back qualify)
- hazard_cnt  out  32  stall-cycle count (only with FWD_PERF_CNT_EN)

## Operation
- Slot state per entry: vld, rd[AW], load. A slot counts as a producer only if vld=1 and rd≠0.
- Per operand i, with ex_rs_used[i]=1 and rs≠0: find the lowest slot k whose producer rd equals rs (the youngest producer).
  - If no slot matches → fwd_sel=0.
  - If slot k matches and is a load with k < LOAD_LAT → operand hazard, fwd_sel=0.
  - Otherwise → fwd_sel=k+1.
- An older matching slot is never selected when a younger one matches, even if the younger one is a hazard.
- Operands with ex_rs_used=0, or rs=0 → fwd_sel=0, no hazard.
- hazard = ex_valid & !flush & OR(operand hazards).
- Slot update, rising edge, in priority order:
  - rst → all slots vld=0, rd=0, load=0.
  - mem_stall=1 → all slots hold; flush is ignored by the unit. The external pipeline clears ex_valid for a flushed instruction.
  - Otherwise, shift: slot k+1 ← slot k, and the slot DEPTH-1 contents retire. Slot 0 then loads as follows:
    - It takes {ex_valid & ex_regw, ex_rd, ex_load} when !hazard & !flush.
    - Otherwise it takes a bubble (vld=0).
- The register file is write-through for the retiring write, so a retiring producer needs no select.
- hazard held over several cycles: a bubble enters each cycle until the load reaches slot LOAD_LAT, then hazard drops and the select points to that slot.

## Timing
- fwd_sel and hazard are combinational from registered slot state and the ex_* inputs, resolved in the same cycle. There is no registered output latency.
- Scoreboard update latency: an instruction is visible in slot 0 one cycle after it is in EX with advance.
- Load-use with LOAD_LAT=1: 1 stall cycle for a back-to-back dependent instruction, then fwd_sel=2.
- Reset values: slots invalid, fwd_sel=0 for every operand, hazard=0, slot_vld=0, hazard_cnt=0.
- Reset mid-stall: scoreboard cleared immediately (asynchronously) and hazard drops the same cycle.

## Configuration
- FWD_PERF_CNT_EN defined:
  - hazard_cnt present.
  - It increments on every rising edge where hazard=1 and mem_stall=0, and saturates at 32'hFFFF_FFFF.
  - Cleared by rst.
- FWD_PERF_CNT_EN undefined: the hazard_cnt port and counter are absent. All other behaviour is identical.

## Structure
- Shared package fwd_pkg:
  - slot entry struct {vld, rd, load}
  - FWD_SEL_RF = 0 constant
  - function computing SW from DEPTH
- One sub-module: fwd_match, instantiated NSRC times. It takes the slot array plus one rs/used pair and returns {sel, hazard} using a youngest-first priority search.
- The top level owns the slot shift register, the hazard OR and the optional counter.

## Test plan
- Back-to-back ALU dependency: add x5 then sub x6,x5,x1 with DEPTH=2 → fwd_sel[0]=1, hazard=0.
- Double producer: x5 written in slot 0 and slot 1 → fwd_sel=1 (youngest). If only slot 1 writes x5 → fwd_sel=2.
- Load-use: lw x7 then add x8,x7,x7 → hazard=1 for 1 cycle, a bubble enters slot 0, then fwd_sel=2 on both operands and hazard=0. With FWD_PERF_CNT_EN, hazard_cnt=1.
- x0 and unused operands:
  - A producer with rd=0 → fwd_sel=0.
  - An operand with ex_rs_used=0 that matches a load in slot 0 → no hazard.
- mem_stall during hazard: hold 3 cycles → slots unchanged, hazard stays 1, hazard_cnt unchanged. Flush together with hazard → hazard=0 and a bubble enters slot 0.
- Async rst asserted mid-load-use (between clock edges) → hazard=0 and slot_vld=0 immediately, before the next edge.
